// File: rtl/dcache2_dirty_flush.sv
// ---------------------------------------------------------------------------
// dcache2_dirty_flush
//   Sweeper for the L2 dcache dirty array (2**ROW_W rows x ROW_N bits).
//   On flush_start it reads each row, issues one writeback per dirty bit over
//   a valid/ready handshake and clears that bit when the writeback is
//   accepted. A store that re-dirties the line being written back suppresses
//   the clear so the line stays dirty.
//
// Ports
//   clk, rst                 clock (posedge), synchronous active-low reset
//   flush_start              start pulse, sampled only in IDLE
//   flush_busy / flush_done  busy level / one-cycle end-of-sweep pulse
//   dr_addr, dr_clkEn        dirty RAM row read (data valid next cycle)
//   dr_data                  dirty RAM row data
//   clr_row, clr_wen,        dirty RAM clear port (one-hot bit enable)
//   clr_bitEn
//   set_addr, set_wen        monitored store-path dirty-set port
//   wb_valid, wb_addr,       writeback request handshake, addr = {bit, row}
//   wb_ready
//   flush_row_first/_last    sweep range (only with DCACHE2_FLUSH_RANGE_EN)
//
// Configuration macro: DCACHE2_FLUSH_RANGE_EN
//   Defined   : sweep covers flush_row_first..flush_row_last (sampled with
//               flush_start); first > last finishes immediately.
//   Undefined : sweep covers every row.
// ---------------------------------------------------------------------------
module dcache2_dirty_flush #(
    parameter int ROW_W  = 5,
    parameter int ROW_N  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_start,
    output logic              flush_busy,
    output logic              flush_done,
    output logic [ROW_W-1:0]  dr_addr,
    output logic              dr_clkEn,
    input  logic [ROW_N-1:0]  dr_data,
    output logic [ROW_W-1:0]  clr_row,
    output logic              clr_wen,
    output logic [ROW_N-1:0]  clr_bitEn,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              set_wen,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_ready
`ifdef DCACHE2_FLUSH_RANGE_EN
    ,
    input  logic [ROW_W-1:0]  flush_row_first,
    input  logic [ROW_W-1:0]  flush_row_last
`endif
);

    localparam int BIT_W = ADDR_W - ROW_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_SCAN,
        S_REQ,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ROW_W-1:0]    last_q, last_d;
    logic [ROW_N-1:0]    mask_q, mask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                pend_q, pend_d;
    logic                busy_q, done_q, rd_q, valid_q;

    logic [ROW_W-1:0]    first_w, last_w;
    logic                accept;
    logic                set_hit;
    logic [BIT_W-1:0]    cur_bit;
    logic [ROW_N-1:0]    cur_onehot;
    logic [ROW_N-1:0]    mask_left;

`ifdef DCACHE2_FLUSH_RANGE_EN
    assign first_w = flush_row_first;
    assign last_w  = flush_row_last;
`else
    assign first_w = '0;
    assign last_w  = '1;
`endif

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [BIT_W-1:0] lowest(input logic [ROW_N-1:0] m);
        logic [BIT_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ROW_N; i++) begin
            if (m[ROW_N-1-i]) r = BIT_W'(ROW_N-1-i);
        end
        return r;
    endfunction

    // rst gates the accept so a reset landing on a handshake never clears.
    assign accept     = (state_q == S_REQ) && wb_ready && rst;
    assign set_hit    = set_wen && (set_addr == addr_q);
    assign cur_bit    = addr_q[ADDR_W-1:ROW_W];
    assign cur_onehot = {{(ROW_N-1){1'b0}}, 1'b1} << cur_bit;
    assign mask_left  = mask_q & ~cur_onehot;

    // The clear must coincide with the accepting handshake, so the clear
    // port is decoded combinationally from the current REQ state.
    assign clr_wen   = accept && !pend_q && !set_hit;
    assign clr_row   = clr_wen ? row_q : '0;
    assign clr_bitEn = clr_wen ? cur_onehot : '0;

    assign flush_busy = busy_q;
    assign flush_done = done_q;
    assign dr_clkEn   = rd_q;
    assign dr_addr    = row_q;
    assign wb_valid   = valid_q;
    assign wb_addr    = addr_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        last_d  = last_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                if (flush_start) begin
                    row_d   = first_w;
                    last_d  = last_w;
                    state_d = (first_w > last_w) ? S_DONE : S_RD;
                end
            end
            S_RD:   state_d = S_CAP;
            S_CAP: begin
                mask_d  = dr_data;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (mask_q == '0) begin
                    if (row_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = S_RD;
                    end
                end else begin
                    addr_d  = {lowest(mask_q), row_q};
                    pend_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (set_hit) pend_d = 1'b1;
                // The accept cycle also makes the following scan decision,
                // so each dirty line costs exactly one REQ cycle.
                if (accept) begin
                    mask_d = mask_left;
                    pend_d = 1'b0;
                    if (mask_left != '0) begin
                        addr_d = {lowest(mask_left), row_q};
                    end else if (row_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            last_q  <= '0;
            mask_q  <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            rd_q    <= (state_d == S_RD);
            valid_q <= (state_d == S_REQ);
        end
    end

endmodule

// File: tb/tb_dcache2_dirty_flush.sv
module tb_dcache2_dirty_flush;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_start, flush_busy, flush_done;
    logic [4:0] dr_addr;
    logic       dr_clkEn;
    logic [7:0] dr_data;
    logic [4:0] clr_row;
    logic       clr_wen;
    logic [7:0] clr_bitEn;
    logic [7:0] set_addr;
    logic       set_wen;
    logic       wb_valid;
    logic [7:0] wb_addr;
    logic       wb_ready;
`ifdef DCACHE2_FLUSH_RANGE_EN
    logic [4:0] row_first, row_last;
`endif

    always #5 clk = ~clk;

    dcache2_dirty_flush #(.ROW_W(5), .ROW_N(8), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done),
        .dr_addr(dr_addr), .dr_clkEn(dr_clkEn), .dr_data(dr_data),
        .clr_row(clr_row), .clr_wen(clr_wen), .clr_bitEn(clr_bitEn),
        .set_addr(set_addr), .set_wen(set_wen),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready)
`ifdef DCACHE2_FLUSH_RANGE_EN
        , .flush_row_first(row_first), .flush_row_last(row_last)
`endif
    );

    // Dirty RAM: registered read, clear port, store-path set port, bench loader.
    logic [7:0] mem [32];
    logic [7:0] rd_data_q;
    logic       ld_en, ld_all;
    logic [4:0] ld_row;
    logic [7:0] ld_data;
    assign dr_data = rd_data_q;

    always @(posedge clk) begin : ram
        logic [7:0] nv;
        for (int i = 0; i < 32; i++) begin
            nv = mem[i];
            if (ld_all) nv = 8'h00;
            else if (ld_en && ld_row == 5'(i)) nv = ld_data;
            else begin
                if (clr_wen && clr_row == 5'(i)) nv = nv & ~clr_bitEn;
                if (set_wen && set_addr[4:0] == 5'(i)) nv = nv | (8'd1 << set_addr[7:5]);
            end
            mem[i] <= nv;
        end
        if (dr_clkEn) rd_data_q <= mem[dr_addr];
    end

    // Reference: spec-level snapshot of the array and the expected writebacks.
    logic [7:0] ref_mem [32];
    logic [7:0] exp_q [$];
    int         ndirty;

    int  vec = 0, errs = 0;
    int  cyc, done_at, n_rd, n_wb, n_stall, n_clr, rd_expect, rd_bad;
    bit  saw_done, expect_clr;
    logic [7:0] one = 8'd1;

    typedef struct {
        int         row;
        logic [7:0] data;
        int         exp_done;
        int         exp_wb;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        ndirty = 0;
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 8; b++)
                if (ref_mem[r][b]) begin
                    exp_q.push_back({3'(b), 5'(r)});
                    ndirty++;
                end
    endtask

    task automatic clear_all();
        ld_all = 1'b1;
        for (int r = 0; r < 32; r++) ref_mem[r] = 8'h00;
        @(negedge clk);
        ld_all = 1'b0;
    endtask

    task automatic load(input int r, input logic [7:0] d);
        ld_en = 1'b1; ld_row = 5'(r); ld_data = d; ref_mem[r] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    function automatic int ram_dirty_rows();
        int n = 0;
        for (int r = 0; r < 32; r++) if (mem[r] != 8'h00) n++;
        return n;
    endfunction

    task automatic begin_sweep(input int first_row);
        n_rd = 0; n_wb = 0; n_stall = 0; n_clr = 0; rd_bad = 0;
        rd_expect = first_row; saw_done = 1'b0; cyc = 0; done_at = -1;
    endtask

    // Inputs for the current cycle are already set; observe, then advance.
    task automatic step();
        logic [7:0] e;
        #1;
        if (dr_clkEn) begin
            if (32'(dr_addr) != rd_expect) rd_bad++;
            rd_expect++;
            n_rd++;
        end
        if (wb_valid && !wb_ready) n_stall++;
        if (clr_wen) n_clr++;
        if (wb_valid && wb_ready && rst) begin
            n_wb++;
            if (exp_q.size() == 0) check("wb_unexpected", 32'(wb_addr), 32'hFFFF);
            else begin
                e = exp_q.pop_front();
                check("wb_addr", 32'(wb_addr), 32'(e));
                if (expect_clr)
                    check("wb_clear", 32'({clr_wen, clr_row, clr_bitEn}),
                          32'({1'b1, e[4:0], one << e[7:5]}));
                else
                    check("wb_noclear", 32'(clr_wen), 32'd0);
            end
        end
        if (flush_done && !saw_done) begin saw_done = 1'b1; done_at = cyc; end
        @(negedge clk);
        cyc++;
    endtask

    task automatic sweep(input bit rnd_ready, input int maxc);
        begin_sweep(0);
        flush_start = 1'b1; wb_ready = 1'b1;
        step();
        flush_start = 1'b0;
        while (!saw_done && cyc < maxc) begin
            wb_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        wb_ready = 1'b0;
        if (!saw_done) check("sweep_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int g = 0;
        while (!wb_valid && g < 300) begin step(); g++; end
        if (!wb_valid) check(name, 32'd0, 32'd1);
    endtask

    initial begin
        int hold, g;
        rst = 1'b0; flush_start = 1'b0; set_wen = 1'b0; set_addr = 8'h00;
        wb_ready = 1'b0; ld_en = 1'b0; ld_all = 1'b0; ld_row = 5'd0; ld_data = 8'h00;
        expect_clr = 1'b1;
`ifdef DCACHE2_FLUSH_RANGE_EN
        row_first = 5'd0; row_last = 5'd31;
`endif
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({flush_busy, flush_done, dr_clkEn, wb_valid, clr_wen,
                                    dr_addr, wb_addr, clr_row, clr_bitEn}), 32'd0);
        rst = 1'b1;
        clear_all();

        // Table-driven single-row patterns with wb_ready held high.
        tbl[0] = '{0,  8'h00, 97,  0};
        tbl[1] = '{3,  8'h81, 99,  2};
        tbl[2] = '{31, 8'hFF, 105, 8};
        tbl[3] = '{0,  8'h01, 98,  1};
        tbl[4] = '{5,  8'h04, 98,  1};
        tbl[5] = '{17, 8'h5A, 101, 4};
        for (int i = 0; i < 6; i++) begin
            clear_all();
            load(tbl[i].row, tbl[i].data);
            build_exp();
            sweep(1'b0, 500);
            check("tbl_done_cycle", 32'(done_at), 32'(tbl[i].exp_done));
            check("tbl_wb_count",   32'(n_wb),    32'(tbl[i].exp_wb));
            check("tbl_clr_count",  32'(n_clr),   32'(tbl[i].exp_wb));
            check("tbl_reads",      32'(n_rd),    32'd32);
            check("tbl_read_order", 32'(rd_bad),  32'd0);
            check("tbl_ram_clean",  32'(ram_dirty_rows()), 32'd0);
        end

        // Random arrays with random wb_ready against the snapshot model.
        for (int it = 0; it < 20; it++) begin
            clear_all();
            for (int r = 0; r < 32; r++)
                if ($urandom_range(0, 3) == 0) load(r, 8'($urandom));
            build_exp();
            sweep(1'b1, 3000);
            check("rnd_done_cycle", 32'(done_at), 32'(97 + ndirty + n_stall));
            check("rnd_wb_count",   32'(n_wb),    32'(ndirty));
            check("rnd_ram_clean",  32'(ram_dirty_rows()), 32'd0);
        end

        // 10-cycle wb_ready stall on line 8'h45.
        clear_all();
        load(5, 8'h04);
        build_exp();
        begin_sweep(0);
        flush_start = 1'b1; wb_ready = 1'b0;
        step();
        flush_start = 1'b0;
        hold = 0; g = 0;
        while (hold < 10 && g < 300) begin
            if (wb_valid && wb_addr == 8'h45 && !clr_wen) hold++;
            step(); g++;
        end
        check("stall_hold_cycles", 32'(hold), 32'd10);
        wb_ready = 1'b1;
        while (!saw_done && cyc < 400) step();
        check("stall_done_cycle", 32'(done_at), 32'd108);
        check("stall_clr_count",  32'(n_clr),   32'd1);

        // Matching store during the REQ stall keeps line 8'hE3 dirty.
        clear_all();
        load(3, 8'h80);
        build_exp();
        expect_clr = 1'b0;
        begin_sweep(0);
        flush_start = 1'b1; wb_ready = 1'b0;
        step();
        flush_start = 1'b0;
        wait_valid("keep_wait_valid");
        set_wen = 1'b1; set_addr = 8'hE3;
        step();
        set_wen = 1'b0;
        step();
        wb_ready = 1'b1;
        while (!saw_done && cyc < 400) step();
        check("keep_wb_count",  32'(n_wb),   32'd1);
        check("keep_clr_count", 32'(n_clr),  32'd0);
        check("keep_ram_bit",   32'(mem[3]), 32'h80);

        // Matching store in the accept cycle itself also suppresses the clear.
        clear_all();
        load(3, 8'h01);
        build_exp();
        begin_sweep(0);
        flush_start = 1'b1; wb_ready = 1'b0;
        step();
        flush_start = 1'b0;
        wait_valid("keep2_wait_valid");
        set_wen = 1'b1; set_addr = 8'h03; wb_ready = 1'b1;
        step();
        set_wen = 1'b0;
        while (!saw_done && cyc < 400) step();
        check("keep2_clr_count", 32'(n_clr),  32'd0);
        check("keep2_ram_bit",   32'(mem[3]), 32'h01);
        expect_clr = 1'b1;

        // Reset while in REQ drops the request; a new sweep reissues it.
        clear_all();
        load(5, 8'h04);
        build_exp();
        begin_sweep(0);
        flush_start = 1'b1; wb_ready = 1'b0;
        step();
        flush_start = 1'b0;
        wait_valid("rst_wait_valid");
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rst_req_outputs", 32'({flush_busy, flush_done, dr_clkEn, wb_valid, clr_wen,
                                      dr_addr, wb_addr, clr_row, clr_bitEn}), 32'd0);
        check("rst_req_ram", 32'(mem[5]), 32'h04);
        build_exp();
        sweep(1'b0, 500);
        check("rst_resweep_wb",   32'(n_wb),    32'd1);
        check("rst_resweep_done", 32'(done_at), 32'd98);

        // flush_start while busy and in DONE is ignored.
        clear_all();
        build_exp();
        begin_sweep(0);
        flush_start = 1'b1;
        step();
        while (!saw_done && cyc < 300) begin
            flush_start = (cyc == 50) || flush_done;
            step();
        end
        flush_start = 1'b0;
        check("ignore_done_cycle", 32'(done_at), 32'd97);
        check("ignore_idle_1", 32'(flush_busy), 32'd0);
        step();
        check("ignore_idle_2", 32'({flush_busy, dr_clkEn}), 32'd0);

`ifdef DCACHE2_FLUSH_RANGE_EN
        // Empty range and single-row range.
        row_first = 5'd5; row_last = 5'd4;
        sweep(1'b0, 300);
        check("range_empty_done",  32'(done_at), 32'd1);
        check("range_empty_reads", 32'(n_rd),    32'd0);
        row_first = 5'd7; row_last = 5'd7;
        begin_sweep(7);
        flush_start = 1'b1; wb_ready = 1'b1;
        step();
        flush_start = 1'b0;
        while (!saw_done && cyc < 300) step();
        check("range_one_reads", 32'(n_rd),    32'd1);
        check("range_one_order", 32'(rd_bad),  32'd0);
        check("range_one_done",  32'(done_at), 32'd4);
        row_first = 5'd0; row_last = 5'd31;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
